// File: rtl/piho_pkg.sv
// Shared types and constants for the piho ring array.
package piho_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StDrain,
        StDone
    } state_e;

    // Per-unit seed slice layout inside the flat seed bus
    localparam int unsigned SEED1_W     = 16;
    localparam int unsigned SEED2_W     = 14;
    localparam int unsigned SEED_STRIDE = 30;

    // Default lattice constants (fixed point)
    localparam logic [32:0] A_DEFAULT    = 33'h2000;
    localparam logic [31:0] AREV_DEFAULT = 32'h80000;

endpackage

// File: rtl/piho_sum_tree.sv
// Registered pairwise adder tree; N inputs, latency $clog2(N)+1 cycles.
// Nodes are heap-indexed: leaves at N..2N-1, root at 1.
module piho_sum_tree #(
    parameter int unsigned N     = 8,
    parameter int unsigned IN_W  = 64,
    parameter int unsigned OUT_W = 67
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N*IN_W-1:0]  data_i,
    output logic [OUT_W-1:0]   sum_o
);

    logic [OUT_W-1:0] node_q [1:2*N-1];

    // Leaves register zero-extended inputs; each inner node registers its children's sum
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < 2 * N; i++) begin
                node_q[i] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                node_q[N + k] <= OUT_W'(data_i[k*IN_W +: IN_W]);
            end
            for (int i = 1; i < N; i++) begin
                node_q[i] <= node_q[2*i] + node_q[2*i + 1];
            end
        end
    end

    assign sum_o = node_q[1];

endmodule

// File: rtl/piho_unit.sv
// Behavioural stand-in for one piho_unit chain: exposes the ring boundary values, a loop
// counter, a finish flag once nconf loops have elapsed, and an x2 value built from its ring
// neighbours (updated only after the warm-up count).
module piho_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] seed1_i,
    input  logic [13:0] seed2_i,
    input  logic [31:0] mc_nconf_i,
    input  logic [31:0] mc_ndump_i,
    input  logic [32:0] a_i,
    input  logic [31:0] arev_i,
    input  logic [31:0] before_i,
    input  logic [31:0] after_i,
    output logic [31:0] first_o,
    output logic [31:0] last_o,
    output logic [63:0] x2sum_real_o,
    output logic        finish_o,
    output logic [31:0] looptimes_o
);

    logic [31:0] looptimes_q;
    logic [63:0] x2sum_q;

    // Loop counter and post-warm-up x2 register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            looptimes_q <= '0;
            x2sum_q     <= '0;
        end else begin
            looptimes_q <= looptimes_q + 32'd1;
            if (looptimes_q >= mc_ndump_i) begin
                x2sum_q <= {before_i, after_i};
            end
        end
    end

    assign first_o      = {2'b11, seed1_i, seed2_i} ^ a_i[31:0] ^ {31'b0, a_i[32]};
    assign last_o       = {seed2_i, seed1_i, 2'b11} ^ arev_i;
    assign x2sum_real_o = x2sum_q;
    assign finish_o     = (looptimes_q >= mc_nconf_i);
    assign looptimes_o  = looptimes_q;

endmodule

// File: rtl/piho_ring_array.sv
// Ring of N_UNITS piho_unit chains with run controller, x2 reduction tree and readback.
module piho_ring_array
    import piho_pkg::*;
#(
    parameter int unsigned N_UNITS = 8,
    parameter int unsigned LOG2N   = $clog2(N_UNITS),
    parameter int unsigned SUM_W   = 64 + LOG2N,
    parameter int unsigned CYC_W   = 48
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic                           abort_i,
    input  logic [SEED_STRIDE*N_UNITS-1:0] seed_i,
    input  logic [31:0]                    mc_nconf_i,
    input  logic [31:0]                    mc_ndump_i,
    input  logic [32:0]                    a_i,
    input  logic [31:0]                    arev_i,
    input  logic [LOG2N-1:0]               rd_sel_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           result_valid_o,
    output logic [SUM_W-1:0]               x2sum_all_o,
    output logic [63:0]                    x2sum_sel_o,
    output logic [31:0]                    looptimes_o,
    output logic [CYC_W-1:0]               run_cycles_o
);

    localparam logic [LOG2N:0] DrainLast = (LOG2N + 1)'(LOG2N);

    state_e                           state_q, state_d;
    logic [SEED_STRIDE*N_UNITS-1:0]   cfg_seed_q;
    logic [31:0]                      cfg_nconf_q, cfg_ndump_q, cfg_arev_q;
    logic [32:0]                      cfg_a_q;
    logic                             cfg_load;
    logic [CYC_W-1:0]                 run_cycles_q, run_cycles_d;
    logic [LOG2N:0]                   drain_cnt_q, drain_cnt_d;
    logic                             done_q, done_d;
    logic                             result_valid_q, result_valid_d;
    logic [SUM_W-1:0]                 x2sum_all_q, x2sum_all_d;
    logic [63:0]                      x2sum_sel_q;
    logic                             finish_prev_q;

    logic                             unit_rst;
    logic [31:0]                      first_w [N_UNITS];
    logic [31:0]                      last_w [N_UNITS];
    logic [63:0]                      x2_w [N_UNITS];
    logic                             finish_w [N_UNITS];
    logic [31:0]                      loop_w [N_UNITS];
    logic [64*N_UNITS-1:0]            x2_flat;
    logic [SUM_W-1:0]                 tree_sum;
    logic                             unused_parity;

    assign unit_rst = ~rst_ni | (state_q == StIdle) | (state_q == StClear);

    for (genvar k = 0; k < N_UNITS; k++) begin : g_unit
        localparam int unsigned Prev = (k + N_UNITS - 1) % N_UNITS;
        localparam int unsigned Next = (k + 1) % N_UNITS;

        piho_unit u_unit (
            .clk_i        (clk_i),
            .rst_i        (unit_rst),
            .seed1_i      (cfg_seed_q[k*SEED_STRIDE +: SEED1_W]),
            .seed2_i      (cfg_seed_q[k*SEED_STRIDE + SEED1_W +: SEED2_W]),
            .mc_nconf_i   (cfg_nconf_q),
            .mc_ndump_i   (cfg_ndump_q),
            .a_i          (cfg_a_q),
            .arev_i       (cfg_arev_q),
            .before_i     (last_w[Prev]),
            .after_i      (first_w[Next]),
            .first_o      (first_w[k]),
            .last_o       (last_w[k]),
            .x2sum_real_o (x2_w[k]),
            .finish_o     (finish_w[k]),
            .looptimes_o  (loop_w[k])
        );

        assign x2_flat[k*64 +: 64] = x2_w[k];
    end

    // Only unit 0 status is consumed; all units share the same config
    always_comb begin
        unused_parity = 1'b0;
        for (int k = 1; k < N_UNITS; k++) begin
            unused_parity = unused_parity ^ finish_w[k] ^ (^loop_w[k]);
        end
    end

    piho_sum_tree #(
        .N     (N_UNITS),
        .IN_W  (64),
        .OUT_W (SUM_W)
    ) u_tree (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .data_i (x2_flat),
        .sum_o  (tree_sum)
    );

    // Run controller next-state; abort overrides start and any in-flight completion
    always_comb begin
        state_d        = state_q;
        cfg_load       = 1'b0;
        run_cycles_d   = run_cycles_q;
        drain_cnt_d    = drain_cnt_q;
        done_d         = 1'b0;
        result_valid_d = result_valid_q;
        x2sum_all_d    = x2sum_all_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i && !abort_i) begin
                    cfg_load = 1'b1;
                    if (mc_nconf_i == 32'd0) begin
                        state_d        = StDone;
                        done_d         = 1'b1;
                        result_valid_d = 1'b1;
                        x2sum_all_d    = '0;
                        run_cycles_d   = '0;
                    end else begin
                        state_d = StClear;
                    end
                end
            end
            StClear: begin
                run_cycles_d   = '0;
                result_valid_d = 1'b0;
                state_d        = StRun;
            end
            StRun: begin
                if (run_cycles_q != '1) begin
                    run_cycles_d = run_cycles_q + 1'b1;
                end
                if (finish_w[0] && !finish_prev_q) begin
                    drain_cnt_d = '0;
                    state_d     = StDrain;
                end
            end
            StDrain: begin
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (drain_cnt_q == DrainLast) begin
                    x2sum_all_d    = tree_sum;
                    result_valid_d = 1'b1;
                    done_d         = 1'b1;
                    state_d        = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort_i && (state_q == StClear || state_q == StRun || state_q == StDrain)) begin
            state_d        = StIdle;
            result_valid_d = 1'b0;
            done_d         = 1'b0;
            x2sum_all_d    = x2sum_all_q;
        end
    end

    // Controller state, config latches and result registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            cfg_seed_q     <= '0;
            cfg_nconf_q    <= '0;
            cfg_ndump_q    <= '0;
            cfg_a_q        <= '0;
            cfg_arev_q     <= '0;
            run_cycles_q   <= '0;
            drain_cnt_q    <= '0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            x2sum_all_q    <= '0;
            x2sum_sel_q    <= '0;
            finish_prev_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            run_cycles_q   <= run_cycles_d;
            drain_cnt_q    <= drain_cnt_d;
            done_q         <= done_d;
            result_valid_q <= result_valid_d;
            x2sum_all_q    <= x2sum_all_d;
            x2sum_sel_q    <= x2_w[rd_sel_i];
            finish_prev_q  <= finish_w[0];
            if (cfg_load) begin
                cfg_seed_q  <= seed_i;
                cfg_nconf_q <= mc_nconf_i;
                cfg_ndump_q <= mc_ndump_i;
                cfg_a_q     <= a_i;
                cfg_arev_q  <= arev_i;
            end
        end
    end

    assign busy_o         = (state_q == StClear) || (state_q == StRun) || (state_q == StDrain);
    assign done_o         = done_q;
    assign result_valid_o = result_valid_q;
    assign x2sum_all_o    = x2sum_all_q;
    assign x2sum_sel_o    = x2sum_sel_q;
    assign looptimes_o    = loop_w[0];
    assign run_cycles_o   = run_cycles_q;

endmodule

// File: tb/tb_piho_ring_array.sv
// Directed/randomised bench for piho_ring_array against a spec-level ring model.
module tb_piho_ring_array;

    localparam int N     = 8;
    localparam int LOG2N = 3;
    localparam int SUM_W = 64 + LOG2N;
    localparam int CYC_W = 48;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start, abort;
    logic [30*N-1:0]    seed;
    logic [31:0]        mc_nconf, mc_ndump, arev_in;
    logic [32:0]        a_in;
    logic [LOG2N-1:0]   rd_sel;
    logic               busy, done, rv;
    logic [SUM_W-1:0]   x2sum_all;
    logic [63:0]        x2sum_sel;
    logic [31:0]        looptimes;
    logic [CYC_W-1:0]   run_cycles;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    piho_ring_array #(.N_UNITS(N)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .abort_i        (abort),
        .seed_i         (seed),
        .mc_nconf_i     (mc_nconf),
        .mc_ndump_i     (mc_ndump),
        .a_i            (a_in),
        .arev_i         (arev_in),
        .rd_sel_i       (rd_sel),
        .busy_o         (busy),
        .done_o         (done),
        .result_valid_o (rv),
        .x2sum_all_o    (x2sum_all),
        .x2sum_sel_o    (x2sum_sel),
        .looptimes_o    (looptimes),
        .run_cycles_o   (run_cycles)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [30*N-1:0] rand_seed();
        logic [30*N-1:0] s;
        for (int k = 0; k < N; k++) s[30*k +: 30] = 30'($urandom());
        return s;
    endfunction

    // Unit k sees last of unit k-1 (high half) and first of unit k+1 (low half), ring modulo N
    function automatic logic [63:0] m_x2(int k, logic [30*N-1:0] sd, logic [32:0] a,
                                         logic [31:0] arev);
        int          kp = (k + N - 1) % N;
        int          kn = (k + 1) % N;
        logic [31:0] last_p, first_n;
        last_p  = {sd[30*kp+16 +: 14], sd[30*kp +: 16], 2'b11} ^ arev;
        first_n = {2'b11, sd[30*kn +: 16], sd[30*kn+16 +: 14]} ^ a[31:0] ^ {31'b0, a[32]};
        return {last_p, first_n};
    endfunction

    function automatic logic [SUM_W-1:0] m_sum(logic [30*N-1:0] sd, logic [32:0] a,
                                               logic [31:0] arev);
        logic [SUM_W-1:0] s = '0;
        for (int k = 0; k < N; k++) s = s + SUM_W'(m_x2(k, sd, a, arev));
        return s;
    endfunction

    task automatic do_run(input logic [30*N-1:0] sd, input logic [31:0] nconf,
                          input logic [31:0] ndump, input logic [32:0] a,
                          input logic [31:0] arev, input bit poke_start,
                          output logic [SUM_W-1:0] expsum);
        int cyc;
        bit saw_done;
        expsum   = m_sum(sd, a, arev);
        seed     = sd;
        mc_nconf = nconf;
        mc_ndump = ndump;
        a_in     = a;
        arev_in  = arev;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        // Config inputs must be ignored once the run has started
        seed     = rand_seed();
        mc_nconf = $urandom();
        mc_ndump = $urandom();
        a_in     = 33'({$urandom(), $urandom()});
        arev_in  = $urandom();
        cyc      = 0;
        saw_done = 0;
        while (busy && cyc < 1000) begin
            cyc++;
            if (done) saw_done = 1;
            start = (poke_start && cyc == 4);
            tick();
        end
        start = 1'b0;
        check("busy_len", 128'(cyc), 128'(nconf + LOG2N + 3));
        check("no_early_done", 128'(saw_done), 128'(0));
        check("done_pulse", 128'(done), 128'(1));
        check("result_valid", 128'(rv), 128'(1));
        check("x2sum_all", 128'(x2sum_all), 128'(expsum));
        check("run_cycles", 128'(run_cycles), 128'(nconf + 1));
        check("looptimes", 128'(looptimes), 128'(nconf + LOG2N + 2));
        tick();
        check("done_one_cycle", 128'(done), 128'(0));
        for (int k = 0; k < N; k++) begin
            rd_sel = LOG2N'(k);
            tick();
            check($sformatf("x2sum_sel[%0d]", k), 128'(x2sum_sel), 128'(m_x2(k, sd, a, arev)));
        end
    endtask

    initial begin
        logic [SUM_W-1:0] exp_sum, prev_sum;
        logic [30*N-1:0]  sd;
        logic [31:0]      nc;
        int               cyc;

        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        seed     = '0;
        mc_nconf = '0;
        mc_ndump = '0;
        a_in     = '0;
        arev_in  = '0;
        rd_sel   = '0;
        #23;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_rv", 128'(rv), 128'(0));
        check("rst_sum", 128'(x2sum_all), 128'(0));
        check("rst_sel", 128'(x2sum_sel), 128'(0));
        check("rst_cycles", 128'(run_cycles), 128'(0));
        check("rst_loop", 128'(looptimes), 128'(0));
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_busy", 128'(busy), 128'(0));

        // Randomised runs, the first also pokes start while busy
        for (int r = 0; r < 2; r++) begin
            nc = 32'($urandom_range(4, 40));
            do_run(rand_seed(), nc, 32'($urandom_range(0, int'(nc) - 1)),
                   33'({$urandom(), $urandom()}), $urandom(), (r == 0), exp_sum);
        end

        // Overflow-free width: every unit's x2 is all ones
        sd = '1;
        do_run(sd, 32'd10, 32'd0, 33'd0, 32'd0, 1'b0, exp_sum);
        check("overflow_const", 128'(x2sum_all), 128'(67'h7_FFFF_FFFF_FFFF_FFF8));
        prev_sum = exp_sum;

        // Abort mid-RUN keeps the old sum and drops result_valid
        seed     = rand_seed();
        mc_nconf = 32'd30;
        mc_ndump = 32'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("abort_pre_busy", 128'(busy), 128'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_done", 128'(done), 128'(0));
        check("abort_rv", 128'(rv), 128'(0));
        check("abort_sum", 128'(x2sum_all), 128'(prev_sum));
        check("abort_units_rst", 128'(looptimes), 128'(0));
        tick();
        tick();
        check("abort_no_late_done", 128'(done), 128'(0));

        // start and abort together: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 128'(busy), 128'(0));
        check("start_abort_done", 128'(done), 128'(0));

        // Zero-configuration shortcut
        mc_nconf = 32'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("zero_done", 128'(done), 128'(1));
        check("zero_busy", 128'(busy), 128'(0));
        check("zero_rv", 128'(rv), 128'(1));
        check("zero_sum", 128'(x2sum_all), 128'(0));
        check("zero_cycles", 128'(run_cycles), 128'(0));
        check("zero_loop", 128'(looptimes), 128'(0));
        tick();
        check("zero_done_pulse", 128'(done), 128'(0));

        // Restart from DONE
        nc = 32'($urandom_range(2, 25));
        do_run(rand_seed(), nc, nc - 32'd1, 33'({$urandom(), $urandom()}), $urandom(), 1'b0,
               exp_sum);

        // Async reset in the middle of DRAIN
        seed     = rand_seed();
        mc_nconf = 32'd12;
        mc_ndump = 32'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (cyc < 16 && busy) begin
            tick();
            cyc++;
        end
        check("drain_busy", 128'(busy), 128'(1));
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 128'(busy), 128'(0));
        check("arst_done", 128'(done), 128'(0));
        check("arst_rv", 128'(rv), 128'(0));
        check("arst_sum", 128'(x2sum_all), 128'(0));
        check("arst_sel", 128'(x2sum_sel), 128'(0));
        check("arst_cycles", 128'(run_cycles), 128'(0));
        check("arst_loop", 128'(looptimes), 128'(0));
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
